// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch unit (master) and imem (slave).
interface fetch_unit_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one instruction at a time over imem,
// presents decoded fields to the controller and advances the PC on retire.
module fetch_unit #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic             i_clk,
    input  logic             i_rst,
    fetch_unit_if.master     imem,
    input  logic             i_pc_sel,
    input  logic [XLEN-1:0]  i_alu_result,
    input  logic             i_instr_retire,
    output logic [XLEN-1:0]  o_pc,
    output logic [XLEN-1:0]  o_pc_plus4,
    output logic [31:0]      o_instr,
    output logic             o_instr_valid,
    output logic [6:0]       o_opcode,
    output logic [2:0]       o_funct3,
    output logic             o_funct7,
    output logic             o_misalign_err,
    output logic [31:0]      o_retired_cnt
);

    typedef enum logic [1:0] {
        StFetch,
        StWait,
        StExec,
        StError
    } state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    logic [31:0]     r_instr;
    logic [31:0]     w_instr_next;
    logic            r_instr_valid;
    logic            w_instr_valid_next;
    logic            r_misalign_err;
    logic            w_misalign_err_next;
    logic [31:0]     r_retired_cnt;
    logic [31:0]     w_retired_cnt_next;
    logic            w_req;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_target;

    assign w_pc_plus4 = r_pc + XLEN'(4);
    // Jump targets drop bit 0 (JALR semantics); bit 1 is what can still be misaligned.
    assign w_target   = i_pc_sel ? (i_alu_result & ~XLEN'(1)) : w_pc_plus4;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= StFetch;
            r_pc           <= RESET_PC;
            r_instr        <= NOP_INSTR;
            r_instr_valid  <= 1'b0;
            r_misalign_err <= 1'b0;
            r_retired_cnt  <= '0;
        end else begin
            r_state        <= w_state_next;
            r_pc           <= w_pc_next;
            r_instr        <= w_instr_next;
            r_instr_valid  <= w_instr_valid_next;
            r_misalign_err <= w_misalign_err_next;
            r_retired_cnt  <= w_retired_cnt_next;
        end
    end

    always_comb begin
        w_state_next        = r_state;
        w_pc_next           = r_pc;
        w_instr_next        = r_instr;
        w_instr_valid_next  = r_instr_valid;
        w_misalign_err_next = r_misalign_err;
        w_retired_cnt_next  = r_retired_cnt;
        w_req               = 1'b0;

        unique case (r_state)
            StFetch: begin
                // Held low during reset so the first request appears with rst deasserted.
                w_req = ~i_rst;
                if (imem.imem_ready) begin
                    if (imem.imem_rvalid) begin
                        w_instr_next       = imem.imem_rdata;
                        w_instr_valid_next = 1'b1;
                        w_state_next       = StExec;
                    end else begin
                        w_state_next = StWait;
                    end
                end
            end
            StWait: begin
                if (imem.imem_rvalid) begin
                    w_instr_next       = imem.imem_rdata;
                    w_instr_valid_next = 1'b1;
                    w_state_next       = StExec;
                end
            end
            StExec: begin
                if (i_instr_retire) begin
                    w_instr_valid_next = 1'b0;
                    w_instr_next       = NOP_INSTR;
                    if (w_target[1]) begin
                        w_misalign_err_next = 1'b1;
                        w_state_next        = StError;
                    end else begin
                        w_pc_next          = w_target;
                        w_retired_cnt_next = r_retired_cnt + 32'd1;
                        w_state_next       = StFetch;
                    end
                end
            end
            StError: begin
                w_instr_valid_next = 1'b0;
                w_instr_next       = NOP_INSTR;
            end
            default: begin
                w_state_next = StFetch;
            end
        endcase
    end

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_pc;

    assign o_pc           = r_pc;
    assign o_pc_plus4     = w_pc_plus4;
    assign o_instr        = r_instr;
    assign o_instr_valid  = r_instr_valid;
    assign o_opcode       = r_instr[6:0];
    assign o_funct3       = r_instr[14:12];
    assign o_funct7       = r_instr[30];
    assign o_misalign_err = r_misalign_err;
    assign o_retired_cnt  = r_retired_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a transaction-level model checked every cycle, plus literal pins.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        pc_sel;
    logic [31:0] alu;
    logic        retire;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        instr_valid;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7;
    logic        misalign_err;
    logic [31:0] retired_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit_if #(.XLEN(32)) u_if ();

    fetch_unit #(
        .XLEN      (32),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) u_dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .imem           (u_if.master),
        .i_pc_sel       (pc_sel),
        .i_alu_result   (alu),
        .i_instr_retire (retire),
        .o_pc           (pc),
        .o_pc_plus4     (pc_plus4),
        .o_instr        (instr),
        .o_instr_valid  (instr_valid),
        .o_opcode       (opcode),
        .o_funct3       (funct3),
        .o_funct7       (funct7),
        .o_misalign_err (misalign_err),
        .o_retired_cnt  (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an instruction is either being requested, outstanding, held, or the unit is dead.
    logic        m_init = 1'b0;
    logic        m_have;
    logic        m_pend;
    logic        m_dead;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_cnt;
    logic [31:0] m_next;
    logic        exp_req;

    assign m_next  = pc_sel ? (alu & 32'hFFFF_FFFE) : m_pc + 32'd4;
    assign exp_req = !rst && m_init && !m_dead && !m_have && !m_pend;

    always @(posedge clk) begin
        if (rst) begin
            m_init  <= 1'b1;
            m_have  <= 1'b0;
            m_pend  <= 1'b0;
            m_dead  <= 1'b0;
            m_pc    <= 32'h0;
            m_instr <= NOP;
            m_cnt   <= 32'h0;
        end else if (m_init && !m_dead) begin
            if (m_have) begin
                if (retire) begin
                    m_have  <= 1'b0;
                    m_instr <= NOP;
                    if (m_next % 4 != 0) begin
                        m_dead <= 1'b1;
                    end else begin
                        m_pc  <= m_next;
                        m_cnt <= m_cnt + 32'd1;
                    end
                end
            end else if (m_pend) begin
                if (u_if.imem_rvalid) begin
                    m_pend  <= 1'b0;
                    m_have  <= 1'b1;
                    m_instr <= u_if.imem_rdata;
                end
            end else if (u_if.imem_ready) begin
                if (u_if.imem_rvalid) begin
                    m_have  <= 1'b1;
                    m_instr <= u_if.imem_rdata;
                end else begin
                    m_pend <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("req", {31'b0, u_if.imem_req}, {31'b0, exp_req});
            if (exp_req) chk("addr", u_if.imem_addr, m_pc);
            chk("pc", pc, m_pc);
            chk("pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("instr", instr, m_instr);
            chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_have});
            chk("opcode", {25'b0, opcode}, {25'b0, m_instr[6:0]});
            chk("funct3", {29'b0, funct3}, {29'b0, m_instr[14:12]});
            chk("funct7", {31'b0, funct7}, {31'b0, m_instr[30]});
            chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_dead});
            chk("retired_cnt", retired_cnt, m_cnt);
        end
    end

    task automatic mem(input logic rdy, input logic rv, input logic [31:0] rd);
        u_if.imem_ready  = rdy;
        u_if.imem_rvalid = rv;
        u_if.imem_rdata  = rd;
    endtask

    task automatic core(input logic ret, input logic sel, input logic [31:0] a);
        retire = ret;
        pc_sel = sel;
        alu    = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        mem(1'b0, 1'b0, 32'h0);
        core(1'b0, 1'b0, 32'h0);
        tick();
        tick();
        chk("lit_rst_pc", pc, 32'h0);
        chk("lit_rst_instr", instr, NOP);
        chk("lit_rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("lit_rst_req", {31'b0, u_if.imem_req}, 32'h0);

        // Zero-wait fetch at 0x0.
        rst = 1'b0;
        mem(1'b1, 1'b1, 32'h0050_0093);
        #1;
        chk("lit_zw_req", {31'b0, u_if.imem_req}, 32'h1);
        chk("lit_zw_addr", u_if.imem_addr, 32'h0);
        tick();
        mem(1'b0, 1'b0, 32'h0);
        chk("lit_zw_valid", {31'b0, instr_valid}, 32'h1);
        chk("lit_zw_opcode", {25'b0, opcode}, 32'h13);
        chk("lit_zw_funct3", {29'b0, funct3}, 32'h0);
        chk("lit_zw_pc4", pc_plus4, 32'h4);
        tick();
        tick();

        // Jump to 0x10 (alu bit 0 dropped).
        core(1'b1, 1'b1, 32'h11);
        tick();
        core(1'b0, 1'b0, 32'h0);
        chk("lit_j10_pc", pc, 32'h10);
        chk("lit_j10_cnt", retired_cnt, 32'd1);
        chk("lit_j10_req", {31'b0, u_if.imem_req}, 32'h1);

        // Slow memory; stale rvalid and stray retire while requesting.
        mem(1'b0, 1'b1, 32'hDEAD_BEEF);
        core(1'b1, 1'b0, 32'h0);
        tick();
        core(1'b0, 1'b0, 32'h0);
        mem(1'b0, 1'b0, 32'h0);
        chk("lit_stale_valid", {31'b0, instr_valid}, 32'h0);
        chk("lit_hold_addr", u_if.imem_addr, 32'h10);
        tick();
        mem(1'b1, 1'b0, 32'h0);
        tick();
        mem(1'b0, 1'b0, 32'h0);
        chk("lit_wait_req", {31'b0, u_if.imem_req}, 32'h0);
        tick();
        tick();
        mem(1'b0, 1'b1, 32'h4000_0033);
        tick();
        mem(1'b0, 1'b0, 32'h0);
        chk("lit_slow_instr", instr, 32'h4000_0033);
        chk("lit_slow_funct7", {31'b0, funct7}, 32'h1);
        chk("lit_slow_opcode", {25'b0, opcode}, 32'h33);

        // Branch to 0x40 from 0x10.
        core(1'b1, 1'b1, 32'h41);
        tick();
        core(1'b0, 1'b0, 32'h0);
        chk("lit_j40_pc", pc, 32'h40);
        chk("lit_j40_addr", u_if.imem_addr, 32'h40);
        chk("lit_j40_cnt", retired_cnt, 32'd2);
        mem(1'b1, 1'b1, 32'h0020_8463);
        tick();
        mem(1'b0, 1'b0, 32'h0);

        // Misaligned target: sticky error, no further requests.
        core(1'b1, 1'b1, 32'h22);
        tick();
        chk("lit_mis_err", {31'b0, misalign_err}, 32'h1);
        chk("lit_mis_pc", pc, 32'h40);
        chk("lit_mis_cnt", retired_cnt, 32'd2);
        for (int i = 0; i < 10; i++) begin
            mem(1'b1, 1'b1, 32'h0000_0093);
            core(1'b1, 1'b0, 32'h0);
            tick();
            chk("lit_err_req", {31'b0, u_if.imem_req}, 32'h0);
        end
        mem(1'b0, 1'b0, 32'h0);
        core(1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        tick();
        chk("lit_clr_err", {31'b0, misalign_err}, 32'h0);
        chk("lit_clr_pc", pc, 32'h0);

        // Reset while waiting; the late response must be discarded.
        rst = 1'b0;
        mem(1'b1, 1'b0, 32'h0);
        tick();
        mem(1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem(1'b0, 1'b1, 32'hFFFF_FFFF);
        #1;
        chk("lit_rw_req", {31'b0, u_if.imem_req}, 32'h1);
        tick();
        chk("lit_rw_valid", {31'b0, instr_valid}, 32'h0);
        mem(1'b1, 1'b0, 32'h0);
        tick();
        mem(1'b0, 1'b1, 32'h0010_0113);
        tick();
        mem(1'b0, 1'b0, 32'h0);
        chk("lit_rw_instr", instr, 32'h0010_0113);

        // PC wrap.
        core(1'b1, 1'b1, 32'hFFFF_FFFC);
        tick();
        core(1'b0, 1'b0, 32'h0);
        chk("lit_wrap_pc", pc, 32'hFFFF_FFFC);
        chk("lit_wrap_pc4", pc_plus4, 32'h0);
        mem(1'b1, 1'b1, 32'h0000_0013);
        tick();
        mem(1'b0, 1'b0, 32'h0);
        core(1'b1, 1'b0, 32'h0);
        tick();
        core(1'b0, 1'b0, 32'h0);
        chk("lit_wrap_new_pc", pc, 32'h0);
        chk("lit_wrap_addr", u_if.imem_addr, 32'h0);
        chk("lit_wrap_cnt", retired_cnt, 32'd2);
        mem(1'b1, 1'b1, 32'h0000_7033);
        tick();
        mem(1'b0, 1'b0, 32'h0);
        chk("lit_f3", {29'b0, funct3}, 32'h7);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
